// File: rtl/pc_redirect_pkg.sv
// Shared types and encodings for the PC redirect controller.
package pc_redirect_pkg;

    // Sequencing states of the halt drain/resume machine.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        RESUME = 2'd3
    } state_e;

    // Next-PC select encoding.
    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_RES = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones, clears only on reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc until all-ones is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Branch redirect, halt drain/resume sequencing and branch statistics.
module pc_redirect_ctrl
    import pc_redirect_pkg::*;
#(
    parameter int unsigned PC_W       = 9,
    parameter int unsigned HALT_DRAIN = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_pcsel,
    input  logic [31:0]      ex_brpc,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             resume,
    input  logic [PC_W-1:0]  resume_pc,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [PC_W-1:0]  pc_target,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             halted,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // Drain counter only needs to hold HALT_DRAIN-1.
    localparam int unsigned DW = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = (HALT_DRAIN > 0) ? DW'(HALT_DRAIN - 1) : '0;

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          inc_branch;
    logic          inc_taken;

    // Upper target bits are beyond the PC register and intentionally dropped.
    logic unused_brpc;
    assign unused_brpc = ^ex_brpc[31:PC_W];

    // State and drain counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state and PC/flush control; halt wins over a same-cycle redirect.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        pc_we      = 1'b0;
        pc_sel     = PCSEL_SEQ;
        pc_target  = '0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        unique case (state_q)
            RUN: begin
                pc_we = !stall;
                if (ex_valid && halt_req) begin
                    pc_we      = 1'b0;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    if (HALT_DRAIN > 0) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = HALTED;
                    end
                end else if (ex_valid && ex_pcsel) begin
                    // Redirect overrides a hazard stall.
                    pc_we      = 1'b1;
                    pc_sel     = PCSEL_BR;
                    pc_target  = ex_brpc[PC_W-1:0];
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end
            end
            DRAIN: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            HALTED: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                if (resume) begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                pc_we      = 1'b1;
                pc_sel     = PCSEL_RES;
                pc_target  = resume_pc;
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                state_d    = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Halted is a pure state decode.
    assign halted = (state_q == HALTED);

    // Only real, non-halt EX branches in RUN are counted.
    always_comb begin
        inc_branch = (state_q == RUN) && ex_valid && ex_is_branch && !halt_req;
        inc_taken  = inc_branch && ex_pcsel;
    end

    sat_counter #(
        .W (CNT_W)
    ) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_branch),
        .count (branch_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_taken),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench: RUN-state vector table plus halt/resume/saturation/reset sequences.
module tb_pc_redirect_ctrl;

    localparam int unsigned PC_W = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ex_valid, ex_is_branch, ex_pcsel, halt_req, stall, resume;
    logic [31:0]     ex_brpc;
    logic [PC_W-1:0] resume_pc;
    logic            halt2, resume2;

    logic            pc_we, flush_ifid, flush_idex, halted;
    logic [1:0]      pc_sel;
    logic [PC_W-1:0] pc_target;
    logic [15:0]     branch_cnt, taken_cnt;

    logic            pc_we2, flush_ifid2, flush_idex2, halted2;
    logic [1:0]      pc_sel2;
    logic [PC_W-1:0] pc_target2;
    logic [1:0]      branch_cnt2, taken_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .PC_W       (PC_W),
        .HALT_DRAIN (3),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_is_branch (ex_is_branch),
        .ex_pcsel     (ex_pcsel),
        .ex_brpc      (ex_brpc),
        .halt_req     (halt_req),
        .stall        (stall),
        .resume       (resume),
        .resume_pc    (resume_pc),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .pc_target    (pc_target),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .halted       (halted),
        .branch_cnt   (branch_cnt),
        .taken_cnt    (taken_cnt)
    );

    // Second instance: zero drain and 2-bit counters, with its own halt/resume.
    pc_redirect_ctrl #(
        .PC_W       (PC_W),
        .HALT_DRAIN (0),
        .CNT_W      (2)
    ) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_is_branch (ex_is_branch),
        .ex_pcsel     (ex_pcsel),
        .ex_brpc      (ex_brpc),
        .halt_req     (halt2),
        .stall        (stall),
        .resume       (resume2),
        .resume_pc    (resume_pc),
        .pc_we        (pc_we2),
        .pc_sel       (pc_sel2),
        .pc_target    (pc_target2),
        .flush_ifid   (flush_ifid2),
        .flush_idex   (flush_idex2),
        .halted       (halted2),
        .branch_cnt   (branch_cnt2),
        .taken_cnt    (taken_cnt2)
    );

    typedef struct {
        logic            v;
        logic            br;
        logic            tk;
        logic            st;
        logic [31:0]     brpc;
        logic            we;
        logic [1:0]      sel;
        logic [PC_W-1:0] tgt;
        logic            fl;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        ex_pcsel     = 1'b0;
        ex_brpc      = 32'h0;
        halt_req     = 1'b0;
        stall        = 1'b0;
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_br;
        int exp_tk;

        //             v     br    tk    st    brpc           we    sel   tgt       fl
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 2'd0, 9'h000, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0140, 1'b1, 2'd1, 9'h140, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FE08, 1'b1, 2'd1, 9'h008, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 2'd0, 9'h000, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0050, 1'b1, 2'd0, 9'h000, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0060, 1'b1, 2'd0, 9'h000, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0070, 1'b0, 2'd0, 9'h000, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_01FC, 1'b1, 2'd1, 9'h1FC, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_00A0, 1'b1, 2'd1, 9'h0A0, 1'b1};

        exp_br    = 0;
        exp_tk    = 0;
        rst_n     = 1'b0;
        resume    = 1'b0;
        resume_pc = '0;
        halt2     = 1'b0;
        resume2   = 1'b0;
        clear_ex();

        // Reset state
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_pc_we", pc_we, 1);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_flush_ifid", flush_ifid, 0);
        chk("rst_flush_idex", flush_idex, 0);
        chk("rst_halted", halted, 0);
        chk("rst_branch_cnt", branch_cnt, 0);
        chk("rst_taken_cnt", taken_cnt, 0);
        tick();

        // RUN-state vector table
        for (int i = 0; i < 9; i++) begin
            ex_valid     = vecs[i].v;
            ex_is_branch = vecs[i].br;
            ex_pcsel     = vecs[i].tk;
            stall        = vecs[i].st;
            ex_brpc      = vecs[i].brpc;
            #1;
            chk($sformatf("vec%0d_pc_we", i), pc_we, vecs[i].we);
            chk($sformatf("vec%0d_pc_sel", i), pc_sel, vecs[i].sel);
            if (vecs[i].sel != 2'd0) begin
                chk($sformatf("vec%0d_pc_target", i), pc_target, vecs[i].tgt);
            end
            chk($sformatf("vec%0d_flush_ifid", i), flush_ifid, vecs[i].fl);
            chk($sformatf("vec%0d_flush_idex", i), flush_idex, vecs[i].fl);
            tick();
            if (vecs[i].v && vecs[i].br) begin
                exp_br++;
                if (vecs[i].tk) exp_tk++;
            end
            chk($sformatf("vec%0d_branch_cnt", i), branch_cnt, exp_br);
            chk($sformatf("vec%0d_taken_cnt", i), taken_cnt, exp_tk);
            chk($sformatf("vec%0d_branch_cnt_w2", i), branch_cnt2, sat3(exp_br));
            chk($sformatf("vec%0d_taken_cnt_w2", i), taken_cnt2, sat3(exp_tk));
        end

        // Halt with simultaneous taken branch: halt wins, no count, 3-cycle drain
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_pcsel     = 1'b1;
        halt_req     = 1'b1;
        ex_brpc      = 32'h0000_0040;
        #1;
        chk("halt_acc_pc_we", pc_we, 0);
        chk("halt_acc_pc_sel", pc_sel, 0);
        chk("halt_acc_flush_ifid", flush_ifid, 1);
        chk("halt_acc_flush_idex", flush_idex, 1);
        tick(); // edge 1
        clear_ex();
        chk("halt_branch_cnt", branch_cnt, exp_br);
        chk("halt_taken_cnt", taken_cnt, exp_tk);
        chk("drain1_halted", halted, 0);
        chk("drain1_pc_we", pc_we, 0);
        chk("drain1_flush_ifid", flush_ifid, 1);
        resume    = 1'b1;
        resume_pc = 9'h100;
        tick(); // edge 2
        resume = 1'b0;
        chk("drain2_halted", halted, 0);
        chk("drain2_flush_idex", flush_idex, 1);
        tick(); // edge 3
        chk("drain3_halted", halted, 0);
        tick(); // edge 4
        chk("halted_rise", halted, 1);
        chk("halted_pc_we", pc_we, 0);
        chk("halted_flush_ifid", flush_ifid, 1);
        ex_valid = 1'b1;
        ex_pcsel = 1'b1;
        ex_brpc  = 32'h0000_0080;
        #1;
        chk("halted_ex_pc_we", pc_we, 0);
        chk("halted_ex_pc_sel", pc_sel, 0);
        clear_ex();

        // Resume from HALTED
        resume    = 1'b1;
        resume_pc = 9'h020;
        #1;
        chk("resume_req_halted", halted, 1);
        tick();
        resume       = 1'b0;
        ex_valid     = 1'b1;
        ex_is_branch = 1'b1;
        ex_pcsel     = 1'b1;
        ex_brpc      = 32'h0000_01AA;
        #1;
        chk("resume_pc_sel", pc_sel, 2);
        chk("resume_pc_target", pc_target, 9'h020);
        chk("resume_pc_we", pc_we, 1);
        chk("resume_flush_ifid", flush_ifid, 1);
        chk("resume_flush_idex", flush_idex, 1);
        chk("resume_halted", halted, 0);
        tick();
        clear_ex();
        chk("resume_branch_cnt", branch_cnt, exp_br);
        chk("resume_taken_cnt", taken_cnt, exp_tk);
        stall = 1'b1;
        #1;
        chk("post_resume_stall_pc_we", pc_we, 0);
        chk("post_resume_pc_sel", pc_sel, 0);
        stall = 1'b0;
        #1;
        chk("post_resume_pc_we", pc_we, 1);

        // Clear counters, then saturate the 2-bit instance
        rst_n = 1'b0;
        #1;
        chk("rst2_branch_cnt", branch_cnt, 0);
        chk("rst2_branch_cnt_w2", branch_cnt2, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ex_valid     = 1'b1;
            ex_is_branch = 1'b1;
            ex_pcsel     = 1'b0;
            tick();
            chk($sformatf("sat%0d_branch_cnt_w2", i), branch_cnt2, sat3(i));
            chk($sformatf("sat%0d_taken_cnt_w2", i), taken_cnt2, 0);
            chk($sformatf("sat%0d_branch_cnt", i), branch_cnt, i);
        end
        clear_ex();

        // Zero-drain halt on the second instance
        ex_valid = 1'b1;
        halt2    = 1'b1;
        #1;
        chk("hd0_acc_pc_we", pc_we2, 0);
        chk("hd0_acc_flush_ifid", flush_ifid2, 1);
        tick();
        halt2 = 1'b0;
        clear_ex();
        chk("hd0_halted", halted2, 1);
        chk("hd0_other_halted", halted, 0);

        // Asynchronous reset in the middle of DRAIN
        ex_valid = 1'b1;
        halt_req = 1'b1;
        tick();
        clear_ex();
        tick();
        chk("mid_drain_pc_we", pc_we, 0);
        chk("mid_drain_halted", halted, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_halted", halted, 0);
        chk("async_rst_pc_we", pc_we, 1);
        chk("async_rst_pc_sel", pc_sel, 0);
        chk("async_rst_flush_ifid", flush_ifid, 0);
        chk("async_rst_flush_idex", flush_idex, 0);
        chk("async_rst_branch_cnt", branch_cnt, 0);
        chk("async_rst_halted_w2", halted2, 0);
        chk("async_rst_branch_cnt_w2", branch_cnt2, 0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_pc_we", pc_we, 1);
        chk("post_rst_halted", halted, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencing controller around the branch-resolution datapath. It takes the EX-stage taken/target result, hazard stall and halt requests, and drives PC write enable, next-PC select and IF/ID / ID/EX flushes. It also runs the halt drain/resume state machine and keeps saturating branch statistics counters. It sits between the EX stage and the fetch/PC register logic in the core top level.

## Interface
- PC_W, 9, PC register width
- HALT_DRAIN, 3, cycles held in DRAIN after halt is accepted (0 allowed)
- CNT_W, 16, statistics counter width

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a real instruction (not a bubble)
- ex_is_branch  in  1  EX instruction is a conditional branch, JAL or JALR
- ex_pcsel  in  1  EX resolved taken (branch taken or jump)
- ex_brpc  in  32  resolved target; bits [31:PC_W] ignored
- halt_req  in  1  EX instruction is the halt instruction
- stall  in  1  load-use / hazard stall request
- resume  in  1  restart request, honoured only in HALTED
- resume_pc  in  PC_W  restart address
- pc_we  out  1  PC register write enable
- pc_sel  out  2  0: PC+4, 1: branch target, 2: resume_pc
- pc_target  out  PC_W  address used when pc_sel != 0
- flush_ifid  out  1  squash IF/ID register
- flush_idex  out  1  squash ID/EX register
- halted  out  1  core halted
- branch_cnt  out  CNT_W  resolved branch/jump count
- taken_cnt  out  CNT_W  taken branch/jump count

## Operation
- States: RUN, DRAIN, HALTED, RESUME. Reset state is RUN; drain counter is 0; both statistics counters are 0.
- RUN, default: pc_sel=0, pc_we=!stall, flush_ifid=0, flush_idex=0.
- RUN with ex_valid & ex_pcsel & !halt_req: redirect.
  - pc_sel=1, pc_target=ex_brpc[PC_W-1:0].
  - pc_we=1, even if stall=1 (redirect overrides stall).
  - flush_ifid=1, flush_idex=1.
  - State stays RUN.
- RUN with ex_valid & halt_req: halt accepted. Halt has priority over ex_pcsel in the same cycle.
  - pc_we=0, flush_ifid=1, flush_idex=1.
  - If HALTED_DRAIN>0 (HALT_DRAIN>0): load counter with HALT_DRAIN-1 and go to DRAIN. Otherwise go directly to HALTED.
- DRAIN: pc_we=0, both flushes 1. Counter decrements each cycle; when the counter is 0, go to HALTED. resume is ignored.
- HALTED: halted=1, pc_we=0, both flushes 1. On resume go to RESUME.
- RESUME (one cycle): pc_sel=2, pc_target=resume_pc, pc_we=1, both flushes 1, halted=0, then RUN. EX inputs are ignored in this cycle.
- Statistics:
  - branch_cnt increments when RUN & ex_valid & ex_is_branch & !halt_req.
  - taken_cnt increments when the same condition holds and ex_pcsel=1.
  - Both saturate at all-ones and clear only on reset.
- EX inputs with ex_valid=0 have no effect in any state.

## Timing
- pc_we, pc_sel, pc_target and the flushes are combinational from state and current inputs. The redirect takes effect on the next clk edge: zero added latency.
- halted is a state decode only; it has no combinational input path.
- After reset release with all inputs low: pc_we=1, pc_sel=0, flushes 0, halted 0.
- Halt accepted at edge N:
  - halted rises after edge N+HALT_DRAIN+1 relative to the accept cycle, i.e. HALT_DRAIN cycles in DRAIN.
  - With HALT_DRAIN=0, halted is 1 right after edge N+1.
- resume sampled high in HALTED at edge M: RESUME during cycle M+1; PC loads resume_pc at edge M+2.
- Back-to-back taken branches in consecutive RUN cycles each redirect. The second can only come from a non-flushed EX, so the flush rules stay consistent.
- rst_n asserted in any state:
  - State, counters and drain counter clear immediately.
  - Outputs take the RUN values at once.

## Structure
- Package pc_redirect_pkg holds the state enum (RUN, DRAIN, HALTED, RESUME) and the pc_sel encoding constants (PCSEL_SEQ=0, PCSEL_BR=1, PCSEL_RES=2).
- Sub-module sat_counter (parameter W; ports clk, rst_n, inc, count) is instantiated twice for the statistics.

## Test plan
- Reset, then ex_valid=1, ex_is_branch=1, ex_pcsel=1, ex_brpc=0x0000_0140 -> same cycle: pc_sel=1, pc_target=0x140, pc_we=1, both flushes 1; branch_cnt=1 and taken_cnt=1 after the edge.
- Taken branch with stall=1, ex_brpc=0xFFFF_FE08 -> pc_we=1, pc_target=0x008 (upper bits truncated).
- halt_req=1 and ex_pcsel=1 together, HALT_DRAIN=3 -> no redirect and counters unchanged; halted rises exactly 4 edges later; resume pulsed during DRAIN is ignored.
- In HALTED, resume=1 with resume_pc=0x020 -> next cycle pc_sel=2, pc_we=1, both flushes 1; following cycle RUN with pc_we=!stall.
- CNT_W=2, five not-taken branches -> branch_cnt holds at 3, taken_cnt stays 0.
- rst_n dropped mid-DRAIN -> halted=0, state RUN, counters 0 without waiting for a clock edge.
